// File: rtl/fifo_rd_packer_pkg.sv
// Shared definitions for the FIFO read-side packer: FSM state encoding,
// default entry width and the lane-mask helper used to build m_keep.
package fifo_rd_packer_pkg;

  // Default width of one FIFO entry; the FIFO and the packer agree on it.
  localparam int unsigned DefaultDataWidth = 8;

  // Packer FSM: collecting lanes, or presenting a word downstream.
  typedef enum logic [0:0] {
    StFill = 1'b0,
    StOut  = 1'b1
  } state_e;

  // Mask with the low n bits set (n filled lanes). Saturates at 32 lanes.
  function automatic logic [31:0] keep_mask(input int unsigned n);
    if (n >= 32) begin
      return '1;
    end
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/fifo_rd_timeout.sv
// Idle counter for partial-word flush. Counts cycles while run is high,
// saturates at TIMEOUT_CYCLES, and clears on any capture or when idle ends.
// Only instantiated when FLUSH_TIMEOUT_EN is defined.
module fifo_rd_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic rclk,
  input  logic rrst_n,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] count_q;

  // Saturating idle counter; restarts whenever the idle condition breaks.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      count_q <= '0;
    end else if (clear || !run) begin
      count_q <= '0;
    end else if (count_q != CntW'(TIMEOUT_CYCLES)) begin
      count_q <= count_q + CntW'(1);
    end
  end

  // Gated by run so a flush never coincides with a fresh read or capture.
  always_comb begin
    expire = run && (count_q == CntW'(TIMEOUT_CYCLES));
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-domain consumer of the async FIFO. Pops DATA_WIDTH-bit entries,
// packs PACK of them (lane 0 in the LSBs) into one word and offers it on a
// valid/ready stream. Optional macro FLUSH_TIMEOUT_EN adds an idle timeout
// that flushes a partial word with m_keep marking only the filled lanes.
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DefaultDataWidth,
  parameter int unsigned PACK           = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                       rclk,
  input  logic                       rrst_n,
  input  logic                       fifo_empty,
  input  logic [DATA_WIDTH-1:0]      fifo_data,
  output logic                       fifo_r_en,
  output logic [DATA_WIDTH*PACK-1:0] m_data,
  output logic [PACK-1:0]            m_keep,
  output logic                       m_valid,
  input  logic                       m_ready
);

  localparam int unsigned CntW = $clog2(PACK + 1);

  state_e                       state_q, state_d;
  logic [CntW-1:0]              lane_cnt_q, lane_cnt_d;
  logic                         inflight_q;
  logic [DATA_WIDTH*PACK-1:0]   data_q, data_d;
  logic                         capture;
  logic                         last_lane;
  logic                         flush;
  logic                         handshake;
  logic [31:0]                  keep_full;

  // The entry popped last cycle is on fifo_data now.
  assign capture   = inflight_q;
  assign last_lane = capture && (lane_cnt_q == CntW'(PACK - 1));
  assign handshake = (state_q == StOut) && m_ready;

`ifdef FLUSH_TIMEOUT_EN
  logic idle_run;

  // Idle only while a partial word waits on an empty FIFO with nothing in flight.
  assign idle_run = (state_q == StFill) && (lane_cnt_q != '0) && !inflight_q && fifo_empty;

  fifo_rd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .run    (idle_run),
    .clear  (capture),
    .expire (flush)
  );
`else
  assign flush = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: fill until the last lane lands (or a flush), then hold until accepted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill: if (last_lane || flush) state_d = StOut;
      StOut:  if (m_ready)            state_d = StFill;
      default:                        state_d = StFill;
    endcase
  end

  // FSM outputs: read issue, stream valid and lane mask.
  always_comb begin
    fifo_r_en = 1'b0;
    m_valid   = 1'b0;
    m_keep    = '0;
    keep_full = keep_mask(int'(lane_cnt_q));
    // Counting the in-flight entry keeps us from over-reading past PACK lanes.
    if (state_q == StFill && !fifo_empty &&
        (int'(lane_cnt_q) + int'(inflight_q) < int'(PACK))) begin
      fifo_r_en = 1'b1;
    end
    if (state_q == StOut) begin
      m_valid = 1'b1;
      m_keep  = keep_full[PACK-1:0];
    end
    m_data = data_q;
  end

  // Packing datapath next state: clear on handshake, else drop the capture into its lane.
  always_comb begin
    data_d     = data_q;
    lane_cnt_d = lane_cnt_q;
    if (handshake) begin
      data_d     = '0;
      lane_cnt_d = '0;
    end else if (capture && (int'(lane_cnt_q) < int'(PACK))) begin
      data_d[int'(lane_cnt_q)*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
      lane_cnt_d = lane_cnt_q + CntW'(1);
    end
  end

  // Packing register, lane counter and in-flight flag.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      data_q     <= '0;
      lane_cnt_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      lane_cnt_q <= lane_cnt_d;
      inflight_q <= fifo_r_en;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: directed scenarios plus a
// randomized run checked against a queue-based packing model.
// Build with FLUSH_TIMEOUT_EN defined to exercise the partial flush.
module tb_fifo_rd_packer;

  localparam int unsigned DW   = 8;
  localparam int unsigned PACK = 4;

  logic              rclk = 1'b0;
  logic              rrst_n;
  logic              fifo_empty;
  logic [DW-1:0]     fifo_data;
  logic              fifo_r_en;
  logic [DW*PACK-1:0] m_data;
  logic [PACK-1:0]   m_keep;
  logic              m_valid;
  logic              m_ready;

  int tests_run = 0;
  int fails     = 0;

  logic [DW-1:0]        fifo_q[$];
  logic [PACK+DW*PACK-1:0] got[$];

  always #5 rclk = ~rclk;

  fifo_rd_packer #(
    .DATA_WIDTH     (DW),
    .PACK           (PACK),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .m_valid    (m_valid),
    .m_ready    (m_ready)
  );

  // One clock of the FIFO model plus beat collection; returns at the negedge.
  task automatic step();
    logic pop;
    #1;
    pop = fifo_r_en && !fifo_empty;
    if (m_valid && m_ready) got.push_back({m_keep, m_data});
    @(posedge rclk);
    if (pop && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
    fifo_empty <= (fifo_q.size() == 0);
    @(negedge rclk);
  endtask

  task automatic push(input logic [DW-1:0] b);
    fifo_q.push_back(b);
    fifo_empty <= 1'b0;
  endtask

  task automatic do_reset();
    @(negedge rclk);
    rrst_n = 1'b0;
    m_ready = 1'b0;
    fifo_q.delete();
    fifo_empty <= 1'b1;
    fifo_data  <= '0;
    step();
    step();
    rrst_n = 1'b1;
    step();
    got.delete();
  endtask

  task automatic test_reset();
    @(negedge rclk);
    rrst_n = 1'b0;
    #1;
    tests_run++;
    if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", m_valid); end
    tests_run++;
    if (m_keep !== 4'h0) begin fails++; $display("FAIL reset_keep got %h exp 0", m_keep); end
    tests_run++;
    if (m_data !== 32'h0) begin fails++; $display("FAIL reset_data got %h exp 0", m_data); end
    tests_run++;
    if (fifo_r_en !== 1'b0) begin fails++; $display("FAIL reset_ren got %b exp 0", fifo_r_en); end
  endtask

  task automatic test_single();
    do_reset();
    m_ready = 1'b1;
    push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
    for (int c = 0; c < 20; c++) step();
    tests_run++;
    if (got.size() != 1) begin
      fails++; $display("FAIL single_count got %0d exp 1", got.size());
    end else begin
      tests_run++;
      if (got[0] !== {4'hF, 32'hD4C3B2A1}) begin
        fails++; $display("FAIL single_beat got %h exp %h", got[0], {4'hF, 32'hD4C3B2A1});
      end
    end
  endtask

  task automatic test_hold();
    logic [7:0] bytes_in[8] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
    int waited;
    do_reset();
    m_ready = 1'b0;
    foreach (bytes_in[i]) push(bytes_in[i]);
    waited = 0;
    while (!m_valid && waited < 20) begin step(); waited++; end
    tests_run++;
    if (!m_valid) begin fails++; $display("FAIL hold_valid_timeout got 0 exp 1"); end
    for (int c = 0; c < 10; c++) begin
      step();
      tests_run++;
      if (m_valid !== 1'b1 || m_data !== 32'hD4C3B2A1 || m_keep !== 4'hF || fifo_r_en !== 1'b0) begin
        fails++;
        $display("FAIL hold_stable cyc %0d got v=%b d=%h k=%h ren=%b exp v=1 d=d4c3b2a1 k=f ren=0",
                 c, m_valid, m_data, m_keep, fifo_r_en);
      end
    end
    m_ready = 1'b1;
    waited = 0;
    while (got.size() < 2 && waited < 30) begin step(); waited++; end
    tests_run++;
    if (got.size() != 2) begin
      fails++; $display("FAIL hold_count got %0d exp 2", got.size());
    end else begin
      tests_run++;
      if (got[0] !== {4'hF, 32'hD4C3B2A1} || got[1] !== {4'hF, 32'h1807F6E5}) begin
        fails++; $display("FAIL hold_order got %h %h exp fd4c3b2a1 f1807f6e5", got[0], got[1]);
      end
    end
  endtask

  task automatic test_empty();
    logic seen_ren, seen_val;
    do_reset();
    m_ready = 1'b1;
    seen_ren = 1'b0;
    seen_val = 1'b0;
    for (int c = 0; c < 50; c++) begin
      seen_ren |= fifo_r_en;
      seen_val |= m_valid;
      step();
    end
    tests_run++;
    if (seen_ren !== 1'b0) begin fails++; $display("FAIL empty_ren got 1 exp 0"); end
    tests_run++;
    if (seen_val !== 1'b0) begin fails++; $display("FAIL empty_valid got 1 exp 0"); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_ready = 1'b1;
    push(8'hAA); push(8'hBB);
    for (int c = 0; c < 4; c++) step();
    rrst_n = 1'b0;
    fifo_q.delete();
    fifo_empty <= 1'b1;
    step();
    rrst_n = 1'b1;
    step();
    got.delete();
    push(8'hCC); push(8'hDD); push(8'hEE); push(8'h11);
    for (int c = 0; c < 30; c++) step();
    tests_run++;
    if (got.size() != 1) begin
      fails++; $display("FAIL reset_mid_count got %0d exp 1", got.size());
    end else begin
      tests_run++;
      if (got[0] !== {4'hF, 32'h11EEDDCC}) begin
        fails++; $display("FAIL reset_mid_beat got %h exp %h", got[0], {4'hF, 32'h11EEDDCC});
      end
    end
  endtask

  task automatic test_partial();
    int waited;
    do_reset();
    m_ready = 1'b0;
    push(8'hAA); push(8'hBB);
    waited = 0;
    while (!m_valid && waited < 40) begin step(); waited++; end
`ifdef FLUSH_TIMEOUT_EN
    tests_run++;
    if (m_valid !== 1'b1 || waited < 17) begin
      fails++; $display("FAIL partial_flush_time got v=%b after %0d exp v=1 after >=17", m_valid, waited);
    end
    tests_run++;
    if (m_data !== 32'h0000BBAA || m_keep !== 4'b0011) begin
      fails++; $display("FAIL partial_flush_word got d=%h k=%b exp d=0000bbaa k=0011", m_data, m_keep);
    end
`else
    tests_run++;
    if (m_valid !== 1'b0) begin
      fails++; $display("FAIL partial_no_flush got v=%b exp 0", m_valid);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic ren_h[40];
    logic val_h[40];
    int first_ren, run_len, first_val;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    for (int c = 0; c < 40; c++) begin
      #1;
      ren_h[c] = fifo_r_en;
      val_h[c] = m_valid;
      step();
    end
    first_ren = -1; first_val = -1; run_len = 0;
    for (int c = 0; c < 40; c++) begin
      if (first_ren < 0 && ren_h[c]) first_ren = c;
      if (first_val < 0 && val_h[c]) first_val = c;
    end
    if (first_ren >= 0) begin
      for (int c = first_ren; c < 40 && ren_h[c]; c++) run_len++;
    end
    tests_run++;
    if (run_len != 4) begin fails++; $display("FAIL b2b_ren_run got %0d exp 4", run_len); end
    tests_run++;
    if (first_ren < 0 || first_val - first_ren != 5) begin
      fails++; $display("FAIL b2b_valid_latency got %0d exp 5", first_val - first_ren);
    end
    tests_run++;
    if (got.size() != 2 || got[0] !== {4'hF, 32'h13121110} || got[1] !== {4'hF, 32'h17161514}) begin
      fails++; $display("FAIL b2b_beats got n=%0d exp 2 words 13121110,17161514", got.size());
    end
  endtask

  task automatic test_random();
    localparam int Words = 8;
    logic [DW*PACK-1:0] exp_w[$];
    logic [DW-1:0] entries[$];
    int pushed, cyc;
    do_reset();
    for (int w = 0; w < Words; w++) begin
      logic [DW*PACK-1:0] word = '0;
      for (int l = 0; l < int'(PACK); l++) begin
        logic [DW-1:0] b = 8'($urandom);
        entries.push_back(b);
        word |= (DW*PACK)'(b) << (DW * l);
      end
      exp_w.push_back(word);
    end
    pushed = 0; cyc = 0;
    while (got.size() < Words && cyc < 1000) begin
      if (pushed < entries.size() && ($urandom % 3) != 0) begin
        push(entries[pushed]);
        pushed++;
      end
      m_ready = 1'($urandom % 2);
      step();
      cyc++;
    end
    tests_run++;
    if (got.size() != Words) begin
      fails++; $display("FAIL random_count got %0d exp %0d", got.size(), Words);
    end
    for (int w = 0; w < Words && w < got.size(); w++) begin
      tests_run++;
      if (got[w] !== {4'hF, exp_w[w]}) begin
        fails++; $display("FAIL random_word %0d got %h exp %h", w, got[w], {4'hF, exp_w[w]});
      end
    end
  endtask

  initial begin
    rrst_n = 1'b0;
    m_ready = 1'b0;
    fifo_empty = 1'b1;
    fifo_data = '0;
    test_reset();
    test_single();
    test_hold();
    test_empty();
    test_reset_mid();
    test_partial();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
